priority_arbiter: RTL
=====================

Name: priority_arbiter

Overview:
- Sequential 4-requester arbiter that shares one resource (bus/port) among requesters req[3:0].
- Two arbitration policies:
  - Fixed priority: req[0] highest, req[3] lowest.
  - Round-robin.
- Adds grant locking, a hold-time limit and a registered valid flag.
- Sits in front of the shared datapath; the encoded grant index drives the datapath select.

Parameters:
- MAX_HOLD, 8, maximum consecutive cycles one owner may keep the grant while others wait; legal range 2..255.
- CW, 8, width of the internal hold counter; must satisfy 2^CW > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- rr_mode  input  1  0 = fixed priority, 1 = round-robin; sampled only at arbitration points
- req  input  4  request vector; a requester holds its bit high for as long as it wants the resource
- gnt  output  4  one-hot grant, registered
- gnt_id  output  2  encoded index of the current owner, registered
- gnt_valid  output  1  high while any grant is active, registered
- preempt  output  1  one-cycle pulse marking the cycle in which a hold-timeout forced a handover

Behaviour:
- Reset (asynchronous, rst=1):
  - State = IDLE.
  - gnt = 4'b0000, gnt_id = 2'b00, gnt_valid = 0, preempt = 0.
  - Internal hold_cnt = 0, last_id = 2'b11, so round-robin search starts at index 0.
  - Reset asserted mid-grant drops all outputs immediately; there is no completion of the current grant.
- States: IDLE, GRANT.
- Winner function W(mask):
  - Fixed mode: lowest set index of req & mask.
  - RR mode: first set index of req & mask, searching last_id+1, last_id+2, … with modulo-4 wrap.
- IDLE:
  - If req == 0: remain in IDLE, outputs stay 0.
  - Else: at the next edge go to GRANT with winner W(4'b1111).
  - Latency: req sampled at edge k → gnt visible after edge k (one-cycle registered latency).
- On every new grant:
  - gnt = one-hot(winner), gnt_id = winner, gnt_valid = 1.
  - last_id = winner, hold_cnt = 0.
- GRANT (owner = gnt_id), evaluated each edge in this priority order:
  1. req[owner] == 0 and (req & ~onehot(owner)) != 0:
     - Hand over directly to W(~onehot(owner)). No idle bubble.
     - preempt = 0.
  2. req[owner] == 0 and no other request:
     - Go to IDLE; gnt = 0, gnt_valid = 0.
     - gnt_id holds its last value.
  3. req[owner] == 1 and hold_cnt == MAX_HOLD-1 and another request is pending:
     - Forced handover to W(~onehot(owner)).
     - preempt = 1 for exactly one cycle.
  4. req[owner] == 1 and hold_cnt == MAX_HOLD-1 and no other request:
     - Keep the owner; hold_cnt = 0; preempt = 0.
  5. Otherwise: keep the owner; hold_cnt = hold_cnt + 1.
- Owner exclusion: the forced handover in case 3 always excludes the current owner, even in fixed mode. A timed-out req[0] therefore yields to the next-highest requester.
- gnt is always one-hot or zero. gnt_valid == |gnt. gnt_id matches gnt whenever gnt_valid = 1.
- rr_mode changes take effect only at the next winner evaluation. A grant in progress is not disturbed.
- Requests not held high are not remembered (no request queuing).

Test Plan:
- Reset/idle:
  - Assert rst mid-grant with req=4'b0110 → gnt=0, gnt_valid=0, gnt_id=0 immediately, before any clock edge.
  - Release rst with req=0 → outputs stay 0.
- Fixed priority:
  - rr_mode=0, req=4'b1010 → after one edge gnt=4'b0010, gnt_id=1.
  - Drop req[1] → next edge gnt=4'b1000, gnt_id=3, no idle cycle between grants.
- Round-robin rotation:
  - rr_mode=1, req=4'b1111 held, each owner drops its req for one cycle after being granted → grant order 0,1,2,3,0.
- Hold timeout:
  - MAX_HOLD=8, rr_mode=0, req[0] high continuously, req[2] asserted at cycle 2 → gnt_id=0 for exactly 8 cycles.
  - Then gnt=4'b0100, with a single-cycle preempt=1 pulse.
- Lone owner timeout:
  - Only req[3] high for 20 cycles → gnt=4'b1000 throughout, preempt never asserts, hold_cnt wraps to 0 every 8 cycles.
- Release to idle:
  - Single req[2] pulse 3 cycles long → gnt=4'b0100 for 3 cycles, then gnt=0, gnt_valid=0, gnt_id stays 2.

Source files
------------

// File: rtl/priority_arbiter.sv
// priority_arbiter: 4-requester arbiter with fixed-priority and round-robin
// policies, grant locking, a hold-time limit with forced handover, and
// registered grant outputs.
module priority_arbiter #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CW       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rr_mode,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid,
  output logic       preempt
);

  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    gnt_d;
  logic [1:0]    gnt_id_d;
  logic          gnt_valid_d;
  logic          preempt_d;
  logic [CW-1:0] hold_cnt, hold_cnt_d;
  logic [1:0]    last_id, last_id_d;

  logic [3:0]    owner_oh;
  logic [3:0]    others;
  logic          take;
  logic [1:0]    win;

  // Winner among the set bits of r: lowest index in fixed mode, or the first
  // index after 'last' (modulo 4) in round-robin mode. Caller ensures r != 0.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic rr,
                                      input logic [1:0] last);
    logic [1:0] idx;
    pick = 2'd0;
    if (!rr) begin
      for (int i = 3; i >= 0; i--) begin
        if (r[i]) pick = 2'(i);
      end
    end else begin
      // Descending scan so the nearest candidate after 'last' is assigned last.
      for (int i = 4; i >= 1; i--) begin
        idx = last + 2'(i);
        if (r[idx]) pick = idx;
      end
    end
  endfunction

  assign owner_oh = 4'b0001 << gnt_id;
  assign others   = req & ~owner_oh;

  // Next-state and next-output decision for each arbitration point.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt;
    gnt_id_d    = gnt_id;
    gnt_valid_d = gnt_valid;
    preempt_d   = 1'b0;
    hold_cnt_d  = hold_cnt;
    last_id_d   = last_id;
    take        = 1'b0;
    win         = gnt_id;

    case (state_q)
      IDLE: begin
        if (|req) begin
          take = 1'b1;
          win  = pick(req, rr_mode, last_id);
        end
      end
      GRANT: begin
        if (!req[gnt_id]) begin
          if (|others) begin
            take = 1'b1;
            win  = pick(others, rr_mode, last_id);
          end else begin
            state_d     = IDLE;
            gnt_d       = 4'b0000;
            gnt_valid_d = 1'b0;
            hold_cnt_d  = '0;
          end
        end else if (hold_cnt == HOLD_LAST) begin
          if (|others) begin
            // Timeout handover always excludes the current owner.
            take      = 1'b1;
            win       = pick(others, rr_mode, last_id);
            preempt_d = 1'b1;
          end else begin
            hold_cnt_d = '0;
          end
        end else begin
          hold_cnt_d = hold_cnt + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (take) begin
      state_d     = GRANT;
      gnt_d       = 4'b0001 << win;
      gnt_id_d    = win;
      gnt_valid_d = 1'b1;
      hold_cnt_d  = '0;
      last_id_d   = win;
    end
  end

  // State and registered outputs; reset drops any grant immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt       <= 4'b0000;
      gnt_id    <= 2'b00;
      gnt_valid <= 1'b0;
      preempt   <= 1'b0;
      hold_cnt  <= '0;
      last_id   <= 2'b11;
    end else begin
      state_q   <= state_d;
      gnt       <= gnt_d;
      gnt_id    <= gnt_id_d;
      gnt_valid <= gnt_valid_d;
      preempt   <= preempt_d;
      hold_cnt  <= hold_cnt_d;
      last_id   <= last_id_d;
    end
  end

endmodule
